// File: rtl/pixel_window_3x3_pkg.sv
// Shared widths and window-layout helper for the 3x3 pixel window builder.
// Window elements are packed row-major, oldest first, p11 in the top bits.
package pixel_window_3x3_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_K    = 3;
  localparam int WIN_BITS = WIN_K * WIN_K * PIX_W;

  typedef logic [PIX_W-1:0] pix_t;

  // One window row; element [WIN_K-1] is the oldest (leftmost) column.
  typedef logic [WIN_K-1:0][PIX_W-1:0] win_row_t;

  function automatic int win_offset(input int r, input int c);
    return (WIN_K * WIN_K - 1 - (r * WIN_K + c)) * PIX_W;
  endfunction

endpackage

// File: rtl/pixel_window_3x3_if.sv
// Pixel stream in, packed 3x3 window out; master drives pixels, slave builds windows.
interface pixel_window_3x3_if;
  import pixel_window_3x3_pkg::*;

  pix_t                pix_in;
  logic                pix_in_valid;
  logic [WIN_BITS-1:0] win_data;
  logic                win_valid;
  logic                frame_done;

  modport master (
    output pix_in, pix_in_valid,
    input  win_data, win_valid, frame_done
  );

  modport slave (
    input  pix_in, pix_in_valid,
    output win_data, win_valid, frame_done
  );

endinterface

// File: rtl/line_buffer.sv
// One image row of pixel storage, indexed by column.
// Read is combinational at the write address, so a write returns the old byte.
module line_buffer
  import pixel_window_3x3_pkg::*;
#(
  parameter int DEPTH = 100,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);

  pix_t mem [DEPTH];

  // NOTE: the RAM has no reset; stale rows are never emitted because the
  // window logic waits for two fresh rows after every reset or frame start.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pixel_window_3x3.sv
// Builds a registered 3x3 window per fully-covered pixel of a raster stream.
// Two line buffers hold the previous rows; three shift registers hold the columns.
module pixel_window_3x3
  import pixel_window_3x3_pkg::*;
#(
  parameter int IMG_WIDTH  = 100,
  parameter int IMG_HEIGHT = 100
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  pixel_window_3x3_if.slave bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  win_row_t            sr_q  [WIN_K];
  win_row_t            sr_d  [WIN_K];
  win_row_t            sr_sh [WIN_K];
  pix_t                col_in [WIN_K];
  logic [WIN_BITS-1:0] win_data_q, win_data_d;
  logic                win_valid_q, win_valid_d;
  logic                frame_done_q, frame_done_d;
  pix_t                lb1_rd, lb2_rd;
  logic                last_col, last_row, emit;

  // lb1 holds the previous row, lb2 the one before; lb2 is refilled from lb1.
  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk   (sys_clk),
    .we    (bus.pix_in_valid),
    .addr  (col_q),
    .wdata (bus.pix_in),
    .rdata (lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
    .clk   (sys_clk),
    .we    (bus.pix_in_valid),
    .addr  (col_q),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  assign col_in[0] = lb2_rd;
  assign col_in[1] = lb1_rd;
  assign col_in[2] = bus.pix_in;

  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RW'(IMG_HEIGHT - 1));
  assign emit     = bus.pix_in_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_data_d   = win_data_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    for (int r = 0; r < WIN_K; r++) begin
      sr_sh[r] = {sr_q[r][WIN_K-2:0], col_in[r]};
      sr_d[r]  = sr_q[r];
    end

    if (bus.pix_in_valid) begin
      for (int r = 0; r < WIN_K; r++) sr_d[r] = sr_sh[r];
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (emit) begin
      win_valid_d  = 1'b1;
      frame_done_d = last_row && last_col;
      for (int r = 0; r < WIN_K; r++) begin
        for (int c = 0; c < WIN_K; c++) begin
          win_data_d[win_offset(r, c) +: PIX_W] = sr_sh[r][WIN_K-1-c];
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < WIN_K; r++) sr_q[r] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_data_q   <= win_data_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      for (int r = 0; r < WIN_K; r++) sr_q[r] <= sr_d[r];
    end
  end

  assign bus.win_data   = win_data_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Scoreboard bench: stimulus pushes hand-computed windows, monitors pop and compare.
// Covers 4x4 and 5x3 instances side by side.
module tb_pixel_window_3x3;
  import pixel_window_3x3_pkg::*;

  typedef struct {
    logic [WIN_BITS-1:0] data;
    logic                fd;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_window_3x3_if bus44 ();
  pixel_window_3x3_if bus53 ();

  pixel_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut44 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus44)
  );

  pixel_window_3x3 #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) u_dut53 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus53)
  );

  exp_t                q44 [$];
  exp_t                q53 [$];
  int                  n_checks = 0;
  int                  n_errors = 0;
  logic [WIN_BITS-1:0] last44   = '0;
  logic [WIN_BITS-1:0] last53   = '0;

  logic [WIN_BITS-1:0] tbl_a [$] = '{
    72'h00_01_02_04_05_06_08_09_0A, 72'h01_02_03_05_06_07_09_0A_0B,
    72'h04_05_06_08_09_0A_0C_0D_0E, 72'h05_06_07_09_0A_0B_0D_0E_0F};
  logic [WIN_BITS-1:0] tbl_b [$] = '{
    72'h64_65_66_68_69_6A_6C_6D_6E, 72'h65_66_67_69_6A_6B_6D_6E_6F,
    72'h68_69_6A_6C_6D_6E_70_71_72, 72'h69_6A_6B_6D_6E_6F_71_72_73};
  logic [WIN_BITS-1:0] tbl_c [$] = '{
    72'h00_01_02_05_06_07_0A_0B_0C, 72'h01_02_03_06_07_08_0B_0C_0D,
    72'h02_03_04_07_08_09_0C_0D_0E};

  task automatic check(input string name, input logic [WIN_BITS-1:0] got,
                       input logic [WIN_BITS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input pix_t v, input logic vld);
    if (sel) begin
      bus53.pix_in       = v;
      bus53.pix_in_valid = vld;
    end else begin
      bus44.pix_in       = v;
      bus44.pix_in_valid = vld;
    end
  endtask

  task automatic send_frame(input bit sel, input int w, input int h, input int base,
                            input int gap, input logic [WIN_BITS-1:0] tbl [$]);
    int   k = 0;
    exp_t e;
    for (int i = 0; i < w * h; i++) begin
      @(negedge clk);
      drive(sel, 8'(base + i), 1'b1);
      if ((i / w) >= 2 && (i % w) >= 2) begin
        e.data = tbl[k];
        e.fd   = (i == w * h - 1);
        k++;
        if (sel) q53.push_back(e); else q44.push_back(e);
      end
      if (gap > 0) begin
        @(negedge clk);
        drive(sel, 8'hEE, 1'b0);
        repeat (gap - 1) @(negedge clk);
        if (sel) check("hold53", bus53.win_data, last53);
        else     check("hold44", bus44.win_data, last44);
      end
    end
    @(negedge clk);
    drive(sel, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    if (sel) check("drain53", 72'(q53.size()), 72'd0);
    else     check("drain44", 72'(q44.size()), 72'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data44"},  bus44.win_data,        '0);
    check({tag, "_valid44"}, 72'(bus44.win_valid),  '0);
    check({tag, "_fd44"},    72'(bus44.frame_done), '0);
    check({tag, "_data53"},  bus53.win_data,        '0);
    check({tag, "_valid53"}, 72'(bus53.win_valid),  '0);
    check({tag, "_fd53"},    72'(bus53.frame_done), '0);
  endtask

  always @(negedge clk) begin
    if (bus44.win_valid || bus44.frame_done) begin
      exp_t e;
      check("valid44", 72'(bus44.win_valid), 72'd1);
      if (q44.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected44: got window %h expected none", bus44.win_data);
      end else begin
        e = q44.pop_front();
        check("win44", bus44.win_data, e.data);
        check("fd44", 72'(bus44.frame_done), 72'(e.fd));
        last44 = e.data;
      end
    end
  end

  always @(negedge clk) begin
    if (bus53.win_valid || bus53.frame_done) begin
      exp_t e;
      check("valid53", 72'(bus53.win_valid), 72'd1);
      if (q53.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected53: got window %h expected none", bus53.win_data);
      end else begin
        e = q53.pop_front();
        check("win53", bus53.win_data, e.data);
        check("fd53", 72'(bus53.frame_done), 72'(e.fd));
        last53 = e.data;
      end
    end
  end

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    send_frame(1'b0, 4, 4, 0, 0, tbl_a);
    send_frame(1'b0, 4, 4, 0, 1000, tbl_a);
    send_frame(1'b0, 4, 4, 100, 0, tbl_b);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b0, 8'(200 + i), 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    rst_n  = 1'b0;
    last44 = '0;
    last53 = '0;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    check_zero("inrst");
    rst_n = 1'b1;
    send_frame(1'b0, 4, 4, 0, 0, tbl_a);

    send_frame(1'b1, 5, 3, 0, 0, tbl_c);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_window_3x3.md
# pixel_window_3x3

Builds a 3x3 sliding pixel window from the 8-bit greyscale pixel stream produced by the UART receiver, and feeds it to the edge-detection kernel. Pixels arrive in raster order, one byte per `valid_flag` pulse. The block stores the two previous image rows in line buffers. For every pixel that completes a full 3x3 neighbourhood, it emits one registered window. No border padding is applied, so each frame yields (IMG_WIDTH-2)×(IMG_HEIGHT-2) windows.

## Interface
- `IMG_WIDTH`, default 100: pixels per row; legal range ≥3.
- `IMG_HEIGHT`, default 100: rows per frame; legal range ≥3.
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `pix_in`  in  8  pixel byte; driven by receiver `para_out`.
- `pix_in_valid`  in  1  single-cycle strobe; driven by receiver `valid_flag`; back-to-back strobes must be accepted.
- `win_data`  out  72  packed window, registered (layout below).
- `win_valid`  out  1  single-cycle strobe; `win_data` is valid this cycle.
- `frame_done`  out  1  single-cycle strobe; last pixel of the frame has been consumed.

## Operation
- Counters:
  - `col` counts 0..IMG_WIDTH-1. `row` counts 0..IMG_HEIGHT-1.
  - Both advance only on `pix_in_valid`.
  - `col` wraps to 0 at IMG_WIDTH-1 and increments `row`.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
  - Counter width is $clog2 of the respective dimension.
- Line buffers:
  - Two buffers, `lb1` and `lb2`, each IMG_WIDTH×8, addressed by `col`, read-before-write.
  - On `pix_in_valid`:
    - top = `lb2[col]`, mid = `lb1[col]`, bot = `pix_in`.
    - Then `lb2[col]` ← `lb1[col]` and `lb1[col]` ← `pix_in`.
- Window shift:
  - Three 3-stage row shift registers (top/mid/bot).
  - Each shifts left by one on `pix_in_valid`; the new column enters at the right.
- Emit condition: `pix_in_valid` with pre-increment `row` ≥2 and `col` ≥2. The window is then centred on (row-1, col-1).
- Packing:
  - Row-major, oldest first.
  - p11 (top-left) in [71:64], p12 in [63:56], p13 in [55:48].
  - p21 in [47:40], p22 in [39:32], p23 in [31:24].
  - p31 in [23:16], p32 in [15:8], p33 (current pixel) in [7:0].
- Rows 0–1 of each frame and cols 0–1 of each row produce no window.
  - Line-buffer contents carried over from the previous frame are therefore never emitted.
- `frame_done` asserts for the last pixel of the frame, coincident with the final `win_valid`.
- No back-pressure: the downstream stage must accept one window per cycle.

## Timing
- Reset values:
  - `win_data`=0, `win_valid`=0, `frame_done`=0.
  - `row`=`col`=0; shift registers = 0.
  - Line-buffer RAM is not reset; its contents are don't-care by construction.
- Latency: pixel strobed at cycle N gives `win_valid`/`frame_done` at N+1, with `win_data` already containing that pixel.
- `win_data` holds its value between strobes.
- Pixel gaps of any length are allowed; state is frozen while `pix_in_valid`=0.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of a new frame. No window is emitted until row 2, col 2 of that new frame.

## Structure
- Shared package holds:
  - `PIX_W`=8 and `WIN_K`=3.
  - `WIN_BITS`=72.
  - A function that returns the bit offset of window element (r,c).
- Sub-module `line_buffer`:
  - Parameterised depth, 8-bit wide.
  - Synchronous write enable; combinational read at the same address; read-before-write.
  - Instantiated twice.

## Test plan
Benches use IMG_WIDTH=IMG_HEIGHT=4 unless stated.
- Frame of pixels 0..15, strobed back-to-back:
  - First `win_valid` comes one cycle after pixel 10: `win_data` = {0,1,2,4,5,6,8,9,10}.
  - Exactly 4 windows are emitted.
  - The last window, {5,6,7,9,10,11,13,14,15}, coincides with `frame_done`.
- Same frame with 1000-cycle gaps (UART pacing) → identical windows and count; `win_data` is stable between strobes.
- Two consecutive frames, the second being 100+i → second frame's first window = {100,101,102,104,105,106,108,109,110}. No first-frame values appear.
- Assert `sys_rst_n` low after 6 pixels, then send a clean frame 0..15 → output identical to the first scenario; all outputs read 0 during reset.
- IMG_WIDTH=5, IMG_HEIGHT=3 with pixels 0..14 → 3 windows: {0,1,2,5,6,7,10,11,12}, {1,2,3,6,7,8,11,12,13}, {2,3,4,7,8,9,12,13,14}. `frame_done` accompanies the last one.
